// File: rtl/ras_ckpt_stack.sv
// Return-address stack with checkpoint/recover for branch-mispredict repair.
// Circular buffer of DEPTH entries; the top entry and pointer/count are exported for checkpointing.
module ras_ckpt_stack #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned AW    = 32,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic          pop,
    input  logic          recover,
    input  logic [PW-1:0] recover_ptr,
    input  logic [CW-1:0] recover_cnt,
    input  logic [AW-1:0] recover_top,
    output logic [AW-1:0] top_addr,
    output logic          top_valid,
    output logic [PW-1:0] ckpt_ptr,
    output logic [CW-1:0] ckpt_cnt,
    output logic [AW-1:0] ckpt_top,
    output logic          overflowed
);

    localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_PUSH,
        OP_POP,
        OP_SWAP,
        OP_RECOVER
    } op_e;

    logic [AW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;

    op_e           w_op;
    logic [PW-1:0] w_ptr_inc;
    logic [PW-1:0] w_ptr_dec;
    logic          w_full;
    logic          w_empty;
    logic [PW-1:0] w_ptr_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_wr_en;
    logic [PW-1:0] w_wr_idx;
    logic [AW-1:0] w_wr_data;
    logic          w_ovf_set;

    assign w_ptr_inc = r_ptr + PW'(1);
    assign w_ptr_dec = r_ptr - PW'(1);
    assign w_full    = (r_cnt == LP_FULL);
    assign w_empty   = (r_cnt == '0);

    // Recover wins over everything; stall only gates the fetch-side push/pop.
    always_comb begin
        w_op = OP_HOLD;
        if (recover) begin
            w_op = OP_RECOVER;
        end else if (!stall) begin
            if (push && pop) begin
                w_op = OP_SWAP;
            end else if (push) begin
                w_op = OP_PUSH;
            end else if (pop) begin
                w_op = OP_POP;
            end
        end
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        w_cnt_nxt = r_cnt;
        w_wr_en   = 1'b0;
        w_wr_idx  = r_ptr;
        w_wr_data = push_addr;
        w_ovf_set = 1'b0;
        case (w_op)
            OP_RECOVER: begin
                w_ptr_nxt = recover_ptr;
                w_cnt_nxt = (recover_cnt > LP_FULL) ? LP_FULL : recover_cnt;
                w_wr_en   = 1'b1;
                w_wr_idx  = recover_ptr;
                w_wr_data = recover_top;
            end
            OP_PUSH: begin
                w_ptr_nxt = w_ptr_inc;
                w_cnt_nxt = w_full ? r_cnt : r_cnt + CW'(1);
                w_wr_en   = 1'b1;
                w_wr_idx  = w_ptr_inc;
                w_ovf_set = w_full;
            end
            OP_POP: begin
                if (!w_empty) begin
                    w_ptr_nxt = w_ptr_dec;
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            OP_SWAP: begin
                // Indirect call-return replaces the top in place.
                w_wr_en   = 1'b1;
                w_cnt_nxt = w_empty ? CW'(1) : r_cnt;
            end
            default: begin
                w_ptr_nxt = r_ptr;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_ptr <= w_ptr_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
            if (w_wr_en) begin
                r_mem[w_wr_idx] <= w_wr_data;
            end
        end
    end

    assign top_addr   = r_mem[r_ptr];
    assign top_valid  = !w_empty;
    assign ckpt_ptr   = r_ptr;
    assign ckpt_cnt   = r_cnt;
    assign ckpt_top   = r_mem[r_ptr];
    assign overflowed = r_ovf;

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Self-checking bench for ras_ckpt_stack (DEPTH=4, AW=32): directed scenarios then
// randomized traffic compared against an array-based reference model.
module tb_ras_ckpt_stack;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned PW    = 2;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          push;
    logic [AW-1:0] push_addr;
    logic          pop;
    logic          recover;
    logic [PW-1:0] recover_ptr;
    logic [CW-1:0] recover_cnt;
    logic [AW-1:0] recover_top;
    logic [AW-1:0] top_addr;
    logic          top_valid;
    logic [PW-1:0] ckpt_ptr;
    logic [CW-1:0] ckpt_cnt;
    logic [AW-1:0] ckpt_top;
    logic          overflowed;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [AW-1:0] m_mem [DEPTH];
    int            m_ptr;
    int            m_cnt;
    bit            m_ovf;

    ras_ckpt_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .push(push), .push_addr(push_addr),
        .pop(pop), .recover(recover), .recover_ptr(recover_ptr), .recover_cnt(recover_cnt),
        .recover_top(recover_top), .top_addr(top_addr), .top_valid(top_valid),
        .ckpt_ptr(ckpt_ptr), .ckpt_cnt(ckpt_cnt), .ckpt_top(ckpt_top), .overflowed(overflowed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour expressed as stack rules on a plain array.
    function automatic void model_step();
        int c;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_ptr = 0;
            m_cnt = 0;
            m_ovf = 0;
        end else if (recover) begin
            c = int'(recover_cnt);
            m_ptr = int'(recover_ptr);
            m_cnt = (c > DEPTH) ? DEPTH : c;
            m_mem[m_ptr] = recover_top;
        end else if (!stall) begin
            if (push && pop) begin
                m_mem[m_ptr] = push_addr;
                if (m_cnt == 0) m_cnt = 1;
            end else if (push) begin
                if (m_cnt == DEPTH) m_ovf = 1;
                m_ptr = (m_ptr + 1) % DEPTH;
                m_mem[m_ptr] = push_addr;
                if (m_cnt < DEPTH) m_cnt++;
            end else if (pop && m_cnt > 0) begin
                m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
                m_cnt--;
            end
        end
    endfunction

    task automatic check_model();
        chk("top_addr",   64'(top_addr),   64'(m_mem[m_ptr]));
        chk("top_valid",  64'(top_valid),  64'(m_cnt != 0));
        chk("ckpt_ptr",   64'(ckpt_ptr),   64'(m_ptr));
        chk("ckpt_cnt",   64'(ckpt_cnt),   64'(m_cnt));
        chk("ckpt_top",   64'(ckpt_top),   64'(m_mem[m_ptr]));
        chk("overflowed", 64'(overflowed), 64'(m_ovf));
    endtask

    task automatic idle_inputs();
        reset = 0; stall = 0; push = 0; pop = 0; recover = 0;
        push_addr = '0; recover_ptr = '0; recover_cnt = '0; recover_top = '0;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_model();
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs(); reset = 1; cyc();
    endtask

    task automatic do_push(input logic [AW-1:0] a);
        idle_inputs(); push = 1; push_addr = a; cyc();
    endtask

    task automatic do_pop();
        idle_inputs(); pop = 1; cyc();
    endtask

    initial begin
        idle_inputs();
        #2;
        do_reset();
        chk("rst_top",   64'(top_addr),   64'h0);
        chk("rst_valid", 64'(top_valid),  64'h0);
        chk("rst_ptr",   64'(ckpt_ptr),   64'h0);
        chk("rst_cnt",   64'(ckpt_cnt),   64'h0);
        chk("rst_ovf",   64'(overflowed), 64'h0);

        // Basic push/pop
        do_push(32'h100);
        do_push(32'h200);
        chk("bp_top", 64'(top_addr), 64'h200);
        chk("bp_cnt", 64'(ckpt_cnt), 64'h2);
        chk("bp_ptr", 64'(ckpt_ptr), 64'h2);
        do_pop();
        chk("bp_pop_top", 64'(top_addr), 64'h100);
        chk("bp_pop_cnt", 64'(ckpt_cnt), 64'h1);

        // Overflow
        do_reset();
        do_push(32'h10); do_push(32'h20); do_push(32'h30); do_push(32'h40); do_push(32'h50);
        chk("ov_cnt", 64'(ckpt_cnt),   64'h4);
        chk("ov_flg", 64'(overflowed), 64'h1);
        chk("ov_top", 64'(top_addr),   64'h50);
        do_pop(); chk("ov_pop1", 64'(top_addr), 64'h40);
        do_pop(); chk("ov_pop2", 64'(top_addr), 64'h30);
        do_pop(); chk("ov_pop3", 64'(top_addr), 64'h20);
        do_pop();
        chk("ov_pop4_cnt",   64'(ckpt_cnt),   64'h0);
        chk("ov_pop4_valid", 64'(top_valid),  64'h0);
        chk("ov_sticky",     64'(overflowed), 64'h1);

        // Empty pop
        do_reset();
        do_pop(); do_pop(); do_pop();
        chk("ep_ptr",   64'(ckpt_ptr),  64'h0);
        chk("ep_cnt",   64'(ckpt_cnt),  64'h0);
        chk("ep_valid", 64'(top_valid), 64'h0);

        // Same-cycle push/pop
        do_reset();
        do_push(32'h100); do_push(32'h200);
        idle_inputs(); push = 1; pop = 1; push_addr = 32'h300; cyc();
        chk("sw_top", 64'(top_addr), 64'h300);
        chk("sw_cnt", 64'(ckpt_cnt), 64'h2);
        chk("sw_ptr", 64'(ckpt_ptr), 64'h2);

        // Recovery after wrong-path pops
        do_reset();
        do_push(32'h100); do_push(32'h200);
        chk("rc_ck_ptr", 64'(ckpt_ptr), 64'h2);
        chk("rc_ck_cnt", 64'(ckpt_cnt), 64'h2);
        chk("rc_ck_top", 64'(ckpt_top), 64'h200);
        do_pop(); do_pop(); do_push(32'h999);
        idle_inputs();
        recover = 1; recover_ptr = 2'd2; recover_cnt = 3'd2; recover_top = 32'h200;
        push = 1; push_addr = 32'h999;
        cyc();
        chk("rc_top", 64'(top_addr), 64'h200);
        chk("rc_cnt", 64'(ckpt_cnt), 64'h2);
        chk("rc_ptr", 64'(ckpt_ptr), 64'h2);

        // Stall, then reset colliding with recover
        idle_inputs(); stall = 1; push = 1; push_addr = 32'hABC; cyc();
        chk("st_top", 64'(top_addr), 64'h200);
        chk("st_cnt", 64'(ckpt_cnt), 64'h2);
        chk("st_ptr", 64'(ckpt_ptr), 64'h2);
        idle_inputs(); stall = 1; recover = 1; recover_ptr = 2'd1; recover_cnt = 3'd7;
        recover_top = 32'h5A5A; cyc();
        chk("st_rc_cnt", 64'(ckpt_cnt), 64'h4);
        chk("st_rc_top", 64'(top_addr), 64'h5A5A);
        idle_inputs(); reset = 1; recover = 1; recover_ptr = 2'd3; recover_cnt = 3'd3;
        recover_top = 32'hDEAD; push = 1; pop = 1; cyc();
        chk("rr_top",   64'(top_addr),   64'h0);
        chk("rr_valid", 64'(top_valid),  64'h0);
        chk("rr_ptr",   64'(ckpt_ptr),   64'h0);
        chk("rr_cnt",   64'(ckpt_cnt),   64'h0);
        chk("rr_ovf",   64'(overflowed), 64'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            reset       = ($urandom_range(0, 99) == 0);
            recover     = ($urandom_range(0, 11) == 0);
            stall       = ($urandom_range(0, 5) == 0);
            push        = ($urandom_range(0, 2) != 0);
            pop         = ($urandom_range(0, 2) != 0);
            push_addr   = $urandom;
            recover_ptr = PW'($urandom_range(0, DEPTH - 1));
            recover_cnt = CW'($urandom_range(0, 7));
            recover_top = $urandom;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ras_ckpt_stack.md
RAS_CKPT_STACK -- requirements
Module: ras_ckpt_stack

Interface
REQ-001 Parameter DEPTH, default 16: number of stack entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter AW, default 32: return-address width in bits.
REQ-003 Derived PW = log2(DEPTH): pointer width; CW = PW+1: count width.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  freezes push and pop; recover still acts.
REQ-007 push  input  1  call fetched; push push_addr.
REQ-008 push_addr  input  AW  return address (call PC+4).
REQ-009 pop  input  1  return fetched; pop top entry.
REQ-010 recover  input  1  mispredict repair from execute.
REQ-011 recover_ptr  input  PW  checkpointed pointer.
REQ-012 recover_cnt  input  CW  checkpointed count.
REQ-013 recover_top  input  AW  checkpointed top-entry value.
REQ-014 top_addr  output  AW  entry at current pointer; predicted return target.
REQ-015 top_valid  output  1  high when count != 0.
REQ-016 ckpt_ptr  output  PW  current pointer, for the branch checkpoint.
REQ-017 ckpt_cnt  output  CW  current count, for the branch checkpoint.
REQ-018 ckpt_top  output  AW  equals top_addr; the checkpointed top value.
REQ-019 overflowed  output  1  sticky; set when a push overwrote a live entry.

Function
REQ-020 Storage SHALL be a DEPTH x AW register array used as a circular buffer indexed by ptr (PW bits).
REQ-021 top_addr, ckpt_* and top_valid SHALL be combinational from registered state, so a push or pop is visible in the cycle after its edge.
REQ-022 Per-cycle priority: recover > (push & pop) > push > pop > hold; push and pop are ignored when stall=1 and recover=0.
REQ-023 Push only: ptr <= ptr+1 modulo DEPTH; entry[ptr+1] <= push_addr; count <= min(count+1, DEPTH).
REQ-024 Push at count==DEPTH SHALL overwrite the oldest entry, keep count at DEPTH, and set overflowed.
REQ-025 Pop only with count>0: ptr <= ptr-1 modulo DEPTH; count <= count-1; the entry is not cleared.
REQ-026 Pop with count==0 SHALL leave ptr and count unchanged, and top_valid stays 0.
REQ-027 Push and pop in the same cycle (indirect call-return) SHALL write entry[ptr] <= push_addr with ptr unchanged; count <= max(count,1).
REQ-028 Recover: ptr <= recover_ptr; count <= recover_cnt; entry[recover_ptr] <= recover_top; push/pop that cycle are dropped.
REQ-029 recover_cnt > DEPTH SHALL be clamped to DEPTH.
REQ-030 overflowed SHALL clear only on reset.
REQ-031 Pointer arithmetic SHALL wrap naturally in PW bits; count SHALL never exceed DEPTH nor underflow.

Reset
REQ-032 When reset=1 at an edge: ptr=0, count=0, overflowed=0, all entries=0. Reset overrides recover, push and pop.
REQ-033 After reset: top_addr=0, top_valid=0, ckpt_ptr=0, ckpt_cnt=0.
REQ-034 Reset asserted mid-sequence SHALL discard all state in one cycle with no partial update.

Verification (DEPTH=4, AW=32)
REQ-035 Basic push/pop: reset; push 0x100, push 0x200.
- After the pushes: top_addr=0x200, ckpt_cnt=2, ckpt_ptr=2.
- Pop once: top_addr=0x100, ckpt_cnt=1.
REQ-036 Overflow: push 0x10, 0x20, 0x30, 0x40, 0x50.
- After the pushes: count=4, overflowed=1, top_addr=0x50.
- Four pops return 0x40, 0x30, 0x20; the fourth pop leaves count=0 and top_valid=0.
REQ-037 Empty pop: after reset, pop for 3 cycles -> ptr=0, count=0, top_valid=0.
REQ-038 Same-cycle push/pop: with top 0x200 at count=2, push=pop=1 with push_addr 0x300 -> top_addr=0x300, count=2, ptr unchanged.
REQ-039 Recovery after wrong-path pops:
- Checkpoint ckpt_ptr=2, ckpt_cnt=2, ckpt_top=0x200.
- Pop twice, then push 0x999.
- Recover with the checkpoint, with push=1 in the same cycle -> top_addr=0x200, count=2, 0x999 not stored.
REQ-040 Stall and mid-operation reset:
- stall=1 with push=1 -> no state change.
- reset=1 together with recover=1 -> all outputs zero next cycle.
